// File: rtl/spm_scratchpad_if.sv
// spm_scratchpad_if
// Bus bundle for the two scratchpad ports: IF (instruction fetch) and MEM (load/store).
//   if_spm_addr / mem_spm_addr         word address
//   if_spm_as_  / mem_spm_as_          access strobe, active-low
//   if_spm_rw   / mem_spm_rw           direction: 1 = read, 0 = write
//   if_spm_wr_data / mem_spm_wr_data   write data
//   if_spm_rd_data / mem_spm_rd_data   registered read data
// The master modport belongs to the pipeline side. The slave modport belongs to the scratchpad.
interface spm_scratchpad_if #(
    parameter int ADDR_W = 12,
    parameter int DATA_W = 32
);
    logic [ADDR_W-1:0] if_spm_addr;
    logic              if_spm_as_;
    logic              if_spm_rw;
    logic [DATA_W-1:0] if_spm_wr_data;
    logic [DATA_W-1:0] if_spm_rd_data;

    logic [ADDR_W-1:0] mem_spm_addr;
    logic              mem_spm_as_;
    logic              mem_spm_rw;
    logic [DATA_W-1:0] mem_spm_wr_data;
    logic [DATA_W-1:0] mem_spm_rd_data;

    modport master (
        output if_spm_addr, if_spm_as_, if_spm_rw, if_spm_wr_data,
        output mem_spm_addr, mem_spm_as_, mem_spm_rw, mem_spm_wr_data,
        input  if_spm_rd_data, mem_spm_rd_data
    );

    modport slave (
        input  if_spm_addr, if_spm_as_, if_spm_rw, if_spm_wr_data,
        input  mem_spm_addr, mem_spm_as_, mem_spm_rw, mem_spm_wr_data,
        output if_spm_rd_data, mem_spm_rd_data
    );
endinterface

// File: rtl/spm_scratchpad.sv
// spm_scratchpad
// Dual-port word scratchpad with single-cycle latency, shared by the IF stage and the MEM stage.
// The two ports are independent, and neither port arbitrates for the other.
// Ports:
//   clk  rising-edge clock
//   rst  synchronous, active-high reset. It clears both read registers and blocks writes on that edge.
//   bus  spm_scratchpad_if.slave, which carries both access ports
// Reads are read-first: a write also returns the old word.
// If both ports write the same address on the same edge, the MEM port wins.
module spm_scratchpad #(
    parameter int ADDR_W = 12,
    parameter int DATA_W = 32,
    parameter int DEPTH  = 4096
) (
    input  logic              clk,
    input  logic              rst,
    spm_scratchpad_if.slave   bus
);

    logic [DATA_W-1:0] r_mem [DEPTH];
    logic [DATA_W-1:0] r_if_rd_data;
    logic [DATA_W-1:0] r_mem_rd_data;

    logic [ADDR_W-1:0] w_if_addr;
    logic [ADDR_W-1:0] w_mem_addr;
    logic              w_if_en;
    logic              w_mem_en;
    logic              w_if_wr;
    logic              w_mem_wr;
    logic              w_if_wr_ok;

    assign w_if_addr  = bus.if_spm_addr;
    assign w_mem_addr = bus.mem_spm_addr;

    // Only a clean 0 counts as an access. An X or Z strobe evaluates non-true,
    // so the guarded writes below never fire on it.
    assign w_if_en  = (bus.if_spm_as_  == 1'b0);
    assign w_mem_en = (bus.mem_spm_as_ == 1'b0);
    assign w_if_wr  = w_if_en  && (bus.if_spm_rw  == 1'b0);
    assign w_mem_wr = w_mem_en && (bus.mem_spm_rw == 1'b0);

    // On a same-address double write, the IF write is dropped so that the MEM port wins.
    assign w_if_wr_ok = w_if_wr && !(w_mem_wr && (w_if_addr == w_mem_addr));

    // The array is never cleared. Reset only blocks writes.
    always_ff @(posedge clk) begin
        if (!rst) begin
            if (w_if_wr_ok) begin
                r_mem[w_if_addr] <= bus.if_spm_wr_data;
            end
            if (w_mem_wr) begin
                r_mem[w_mem_addr] <= bus.mem_spm_wr_data;
            end
        end
    end

    // Non-blocking reads sample the array before this edge's writes land.
    // That gives read-first behaviour both within a port and across ports.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_if_rd_data  <= '0;
            r_mem_rd_data <= '0;
        end else begin
            if (w_if_en) begin
                r_if_rd_data <= r_mem[w_if_addr];
            end
            if (w_mem_en) begin
                r_mem_rd_data <= r_mem[w_mem_addr];
            end
        end
    end

    assign bus.if_spm_rd_data  = r_if_rd_data;
    assign bus.mem_spm_rd_data = r_mem_rd_data;

endmodule

// File: tb/tb_spm_scratchpad.sv
// tb_spm_scratchpad
// Directed scenarios, then a randomized phase checked against an array-based reference model.
module tb_spm_scratchpad;

    logic clk = 1'b0;
    logic rst = 1'b1;

    int checks = 0;
    int errors = 0;

    spm_scratchpad_if #(.ADDR_W(12), .DATA_W(32)) bus ();

    spm_scratchpad #(.ADDR_W(12), .DATA_W(32), .DEPTH(4096)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    // Reference model: plain word array, plus a flag for each word that has a known value.
    logic [31:0] mdl [4096];
    bit          mk  [4096];
    logic [31:0] exp_if  = 32'h0;
    logic [31:0] exp_mem = 32'h0;
    bit          exp_if_k  = 1'b0;
    bit          exp_mem_k = 1'b0;

    // Advance one rising edge and apply the access rules to the model:
    // reads see the pre-edge array, then the IF write lands, then the MEM write lands (so MEM wins).
    task automatic cycle();
        @(posedge clk);
        if (rst) begin
            exp_if = 32'h0; exp_if_k = 1'b1;
            exp_mem = 32'h0; exp_mem_k = 1'b1;
        end else begin
            if (bus.if_spm_as_ == 1'b0) begin
                exp_if   = mdl[bus.if_spm_addr];
                exp_if_k = mk[bus.if_spm_addr];
            end
            if (bus.mem_spm_as_ == 1'b0) begin
                exp_mem   = mdl[bus.mem_spm_addr];
                exp_mem_k = mk[bus.mem_spm_addr];
            end
            if (bus.if_spm_as_ == 1'b0 && bus.if_spm_rw == 1'b0) begin
                mdl[bus.if_spm_addr] = bus.if_spm_wr_data;
                mk[bus.if_spm_addr]  = 1'b1;
            end
            if (bus.mem_spm_as_ == 1'b0 && bus.mem_spm_rw == 1'b0) begin
                mdl[bus.mem_spm_addr] = bus.mem_spm_wr_data;
                mk[bus.mem_spm_addr]  = 1'b1;
            end
        end
        #1;
    endtask

    task automatic drive_if(input logic as_n, input logic rw, input logic [11:0] a, input logic [31:0] d);
        bus.if_spm_as_     = as_n;
        bus.if_spm_rw      = rw;
        bus.if_spm_addr    = a;
        bus.if_spm_wr_data = d;
    endtask

    task automatic drive_mem(input logic as_n, input logic rw, input logic [11:0] a, input logic [31:0] d);
        bus.mem_spm_as_     = as_n;
        bus.mem_spm_rw      = rw;
        bus.mem_spm_addr    = a;
        bus.mem_spm_wr_data = d;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        drive_if(1'b1, 1'b1, 12'd0, 32'h0);
        drive_mem(1'b1, 1'b1, 12'd0, 32'h0);
        for (int i = 0; i < 2; i++) begin
            cycle();
            checks++;
            if (bus.if_spm_rd_data !== 32'h0) begin
                errors++; $display("FAIL reset_if actual=%h expected=%h", bus.if_spm_rd_data, 32'h0);
            end
            checks++;
            if (bus.mem_spm_rd_data !== 32'h0) begin
                errors++; $display("FAIL reset_mem actual=%h expected=%h", bus.mem_spm_rd_data, 32'h0);
            end
        end
        rst = 1'b0;
        for (int i = 0; i < 20; i++) begin
            cycle();
            checks++;
            if (bus.if_spm_rd_data !== 32'h0 || bus.mem_spm_rd_data !== 32'h0) begin
                errors++;
                $display("FAIL reset_idle_hold cyc=%0d if=%h mem=%h expected=0", i, bus.if_spm_rd_data, bus.mem_spm_rd_data);
            end
        end
    endtask

    task automatic test_if_seq();
        for (int i = 0; i < 16; i++) begin
            drive_if(1'b0, 1'b0, 12'(i), 32'(255 - i));
            cycle();
        end
        drive_if(1'b1, 1'b1, 12'd0, 32'h0);
        repeat (20) cycle();
        for (int i = 0; i < 16; i++) begin
            drive_if(1'b0, 1'b1, 12'(i), 32'h0);
            cycle();
            checks++;
            if (bus.if_spm_rd_data !== 32'(255 - i)) begin
                errors++; $display("FAIL if_seq_read addr=%0d actual=%h expected=%h", i, bus.if_spm_rd_data, 32'(255 - i));
            end
        end
    endtask

    task automatic test_idle_hold();
        drive_if(1'b0, 1'b1, 12'd3, 32'h0);
        cycle();
        checks++;
        if (bus.if_spm_rd_data !== 32'd252) begin
            errors++; $display("FAIL idle_read3 actual=%h expected=%h", bus.if_spm_rd_data, 32'd252);
        end
        for (int i = 0; i < 10; i++) begin
            drive_if(1'b1, 1'($urandom_range(1)), 12'($urandom_range(15)), $urandom);
            drive_mem(1'b1, 1'($urandom_range(1)), 12'($urandom_range(15)), $urandom);
            cycle();
            checks++;
            if (bus.if_spm_rd_data !== 32'd252) begin
                errors++; $display("FAIL idle_hold cyc=%0d actual=%h expected=%h", i, bus.if_spm_rd_data, 32'd252);
            end
        end
        for (int i = 0; i < 16; i++) begin
            drive_if(1'b0, 1'b1, 12'(i), 32'h0);
            cycle();
            checks++;
            if (bus.if_spm_rd_data !== 32'(255 - i)) begin
                errors++; $display("FAIL idle_array_intact addr=%0d actual=%h expected=%h", i, bus.if_spm_rd_data, 32'(255 - i));
            end
        end
        drive_if(1'b1, 1'b1, 12'd0, 32'h0);
    endtask

    task automatic test_read_first();
        drive_if(1'b0, 1'b0, 12'd5, 32'hDEADBEEF);
        cycle();
        checks++;
        if (bus.if_spm_rd_data !== 32'd250) begin
            errors++; $display("FAIL read_first_old actual=%h expected=%h", bus.if_spm_rd_data, 32'd250);
        end
        drive_if(1'b0, 1'b1, 12'd5, 32'h0);
        cycle();
        checks++;
        if (bus.if_spm_rd_data !== 32'hDEADBEEF) begin
            errors++; $display("FAIL read_first_new actual=%h expected=%h", bus.if_spm_rd_data, 32'hDEADBEEF);
        end
        drive_if(1'b1, 1'b1, 12'd0, 32'h0);
    endtask

    task automatic test_dual_port();
        drive_mem(1'b0, 1'b0, 12'd200, 32'h22);
        cycle();
        drive_if(1'b0, 1'b0, 12'd100, 32'h11);
        drive_mem(1'b0, 1'b1, 12'd200, 32'h0);
        cycle();
        checks++;
        if (bus.mem_spm_rd_data !== 32'h22) begin
            errors++; $display("FAIL dual_mem_read actual=%h expected=%h", bus.mem_spm_rd_data, 32'h22);
        end
        drive_if(1'b0, 1'b0, 12'd300, 32'hA);
        drive_mem(1'b0, 1'b0, 12'd300, 32'hB);
        cycle();
        drive_if(1'b0, 1'b1, 12'd300, 32'h0);
        drive_mem(1'b0, 1'b1, 12'd100, 32'h0);
        cycle();
        checks++;
        if (bus.if_spm_rd_data !== 32'hB) begin
            errors++; $display("FAIL ww_collision actual=%h expected=%h", bus.if_spm_rd_data, 32'hB);
        end
        checks++;
        if (bus.mem_spm_rd_data !== 32'h11) begin
            errors++; $display("FAIL dual_if_write_seen actual=%h expected=%h", bus.mem_spm_rd_data, 32'h11);
        end
    endtask

    task automatic test_cross_rw();
        drive_if(1'b0, 1'b1, 12'd5, 32'h0);
        drive_mem(1'b0, 1'b0, 12'd5, 32'h12345678);
        cycle();
        checks++;
        if (bus.if_spm_rd_data !== 32'hDEADBEEF) begin
            errors++; $display("FAIL cross_rw_old actual=%h expected=%h", bus.if_spm_rd_data, 32'hDEADBEEF);
        end
        drive_if(1'b1, 1'b1, 12'd0, 32'h0);
        drive_mem(1'b0, 1'b1, 12'd5, 32'h0);
        cycle();
        checks++;
        if (bus.mem_spm_rd_data !== 32'h12345678) begin
            errors++; $display("FAIL cross_rw_new actual=%h expected=%h", bus.mem_spm_rd_data, 32'h12345678);
        end
        drive_mem(1'b1, 1'b1, 12'd0, 32'h0);
    endtask

    task automatic test_reset_mid();
        drive_if(1'b0, 1'b0, 12'd7, 32'h77);
        rst = 1'b1;
        cycle();
        checks++;
        if (bus.if_spm_rd_data !== 32'h0 || bus.mem_spm_rd_data !== 32'h0) begin
            errors++; $display("FAIL reset_mid_clear if=%h mem=%h expected=0", bus.if_spm_rd_data, bus.mem_spm_rd_data);
        end
        rst = 1'b0;
        drive_if(1'b1, 1'b1, 12'd0, 32'h0);
        cycle();
        checks++;
        if (bus.if_spm_rd_data !== 32'h0) begin
            errors++; $display("FAIL reset_mid_hold actual=%h expected=%h", bus.if_spm_rd_data, 32'h0);
        end
        drive_if(1'b0, 1'b1, 12'd7, 32'h0);
        cycle();
        checks++;
        if (bus.if_spm_rd_data !== 32'd248) begin
            errors++; $display("FAIL reset_mid_retain actual=%h expected=%h", bus.if_spm_rd_data, 32'd248);
        end
        drive_if(1'b1, 1'b1, 12'd0, 32'h0);
    endtask

    // A small address window forces frequent same-address collisions between the ports.
    task automatic test_random();
        for (int i = 0; i < 400; i++) begin
            rst = ($urandom_range(49) == 0);
            drive_if(1'($urandom_range(3) == 0), 1'($urandom_range(1)), 12'($urandom_range(15)), $urandom);
            drive_mem(1'($urandom_range(3) == 0), 1'($urandom_range(1)), 12'($urandom_range(15)), $urandom);
            cycle();
            if (exp_if_k) begin
                checks++;
                if (bus.if_spm_rd_data !== exp_if) begin
                    errors++; $display("FAIL rand_if cyc=%0d actual=%h expected=%h", i, bus.if_spm_rd_data, exp_if);
                end
            end
            if (exp_mem_k) begin
                checks++;
                if (bus.mem_spm_rd_data !== exp_mem) begin
                    errors++; $display("FAIL rand_mem cyc=%0d actual=%h expected=%h", i, bus.mem_spm_rd_data, exp_mem);
                end
            end
        end
        rst = 1'b0;
        drive_if(1'b1, 1'b1, 12'd0, 32'h0);
        drive_mem(1'b1, 1'b1, 12'd0, 32'h0);
    endtask

    initial begin
        for (int i = 0; i < 4096; i++) begin
            mdl[i] = 32'h0;
            mk[i]  = 1'b0;
        end
        test_reset();
        test_if_seq();
        test_idle_hold();
        test_read_first();
        test_dual_port();
        test_cross_rw();
        test_reset_mid();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
